// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported req/ack memory between instruction fetch and MEM-stage data access.
// Data wins by default; a grant streak counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic        dm_signextend,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_misaligned,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_e;

    state_e              state_q;
    logic [STREAK_W-1:0] streak_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [3:0]          mem_be_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [31:0]         if_rdata_q;
    logic                if_valid_q;
    logic [31:0]         dm_rdata_q;
    logic                dm_done_q;
    logic                dm_misaligned_q;
    // Attributes of the in-flight data access, latched at grant
    logic                byte_q;
    logic                sext_q;
    logic [1:0]          lane_q;
    logic                misal_q;

    logic                starve_c;
    logic                grant_dm_c;
    logic [STREAK_W-1:0] streak_d;
    logic [3:0]          dm_be_c;
    logic [31:0]         dm_wdata_c;
    logic [7:0]          rd_byte_c;
    logic [31:0]         dm_fmt_c;
    logic                unused_c;

    assign unused_c = ^if_addr[1:0];

    // Grant decision and streak update for the IDLE state
    always_comb begin
        starve_c   = if_req && (streak_q == STREAK_W'(STARVE_LIMIT));
        grant_dm_c = dm_req && !starve_c;
        streak_d   = '0;
        if (if_req) begin
            streak_d = (streak_q == STREAK_W'(STARVE_LIMIT)) ? streak_q
                                                              : streak_q + STREAK_W'(1);
        end
    end

    // Store lane steering and load formatting
    always_comb begin
        dm_be_c    = dm_byte ? (4'b0001 << dm_addr[1:0]) : 4'hF;
        dm_wdata_c = dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
        case (lane_q)
            2'd0:    rd_byte_c = mem_rdata[7:0];
            2'd1:    rd_byte_c = mem_rdata[15:8];
            2'd2:    rd_byte_c = mem_rdata[23:16];
            default: rd_byte_c = mem_rdata[31:24];
        endcase
        dm_fmt_c = byte_q ? {{24{sext_q & rd_byte_c[7]}}, rd_byte_c} : mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            streak_q        <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_be_q        <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            if_rdata_q      <= '0;
            if_valid_q      <= 1'b0;
            dm_rdata_q      <= '0;
            dm_done_q       <= 1'b0;
            dm_misaligned_q <= 1'b0;
            byte_q          <= 1'b0;
            sext_q          <= 1'b0;
            lane_q          <= '0;
            misal_q         <= 1'b0;
        end else begin
            if_valid_q      <= 1'b0;
            dm_done_q       <= 1'b0;
            dm_misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dm_c) begin
                        state_q     <= DM_BUSY;
                        streak_q    <= streak_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_be_q    <= dm_be_c;
                        mem_addr_q  <= {dm_addr[31:2], 2'b00};
                        mem_wdata_q <= dm_wdata_c;
                        byte_q      <= dm_byte;
                        sext_q      <= dm_signextend;
                        lane_q      <= dm_addr[1:0];
                        misal_q     <= !dm_byte && (dm_addr[1:0] != 2'b00);
                    end else if (if_req) begin
                        state_q    <= IF_BUSY;
                        streak_q   <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_be_q   <= 4'hF;
                        mem_addr_q <= {if_addr[31:2], 2'b00};
                    end else begin
                        streak_q <= '0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_rdata_q <= mem_rdata;
                        if_valid_q <= 1'b1;
                    end
                end
                DM_BUSY: begin
                    if (mem_ack) begin
                        state_q         <= IDLE;
                        mem_req_q       <= 1'b0;
                        mem_we_q        <= 1'b0;
                        dm_rdata_q      <= dm_fmt_c;
                        dm_done_q       <= 1'b1;
                        dm_misaligned_q <= misal_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_be        = mem_be_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign if_rdata      = if_rdata_q;
    assign if_valid      = if_valid_q;
    assign dm_rdata      = dm_rdata_q;
    assign dm_done       = dm_done_q;
    assign dm_misaligned = dm_misaligned_q;
    assign stall_if      = if_req & ~if_valid_q;
    assign stall_mem     = dm_req & ~dm_done_q;

endmodule
